if_fetch_unit: RTL

Instruction-fetch stage for the 5-stage MIPS pipeline, sitting directly upstream of the ID stage. It owns the PC register and drives a variable-latency instruction-memory request/ready handshake. It produces the IF/ID latch contents (npc, instruction, valid) and honours a hazard stall from ID and a branch redirect (PCSrc) from EX/MEM. Flushes and stalls are handled so that no instruction is lost, duplicated or fetched from a stale address.

---
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// IF-stage bundle: hazard/redirect inputs, instruction-memory handshake and IF/ID latch outputs.
// master = fetch unit side, slave = pipeline/memory environment side.
interface if_fetch_unit_if #(
   parameter int IMEM_AW = 8
);
   logic               stall;
   logic               pcsrc;
   logic [31:0]        branch_target;
   logic               imem_req;
   logic [IMEM_AW-1:0] imem_addr;
   logic               imem_ready;
   logic [31:0]        imem_rdata;
   logic [31:0]        pc;
   logic [31:0]        if_id_npc;
   logic [31:0]        if_id_instr;
   logic               if_id_valid;

   modport master (
      input  stall, pcsrc, branch_target, imem_ready, imem_rdata,
      output imem_req, imem_addr, pc, if_id_npc, if_id_instr, if_id_valid
   );

   modport slave (
      output stall, pcsrc, branch_target, imem_ready, imem_rdata,
      input  imem_req, imem_addr, pc, if_id_npc, if_id_instr, if_id_valid
   );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns PC, drives a req/ready imem port, fills IF/ID; 1 cycle per fetch plus memory waits.
// A stall parks a returned word in HOLD; a redirect during a pending request drains it in DRAIN.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 8
) (
   input logic           clk,
   input logic           rst,
   if_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_n;
   logic [31:0]        r_pc;
   logic [31:0]        w_pc_n;
   logic [31:0]        r_hold_instr;
   logic [31:0]        w_hold_instr_n;
   logic [IMEM_AW-1:0] r_drain_addr;
   logic [IMEM_AW-1:0] w_drain_addr_n;
   logic [31:0]        r_npc;
   logic [31:0]        w_npc_n;
   logic [31:0]        r_instr;
   logic [31:0]        w_instr_n;
   logic               r_valid;
   logic               w_valid_n;

   logic [31:0]        w_pc_plus4;
   logic [IMEM_AW-1:0] w_pc_word;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_pc_word  = r_pc[IMEM_AW+1:2];

   // Request side depends only on state/registers (and reset), never on ready/stall/pcsrc.
   assign bus.imem_req    = rst && (r_state != S_HOLD);
   assign bus.imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : w_pc_word;
   assign bus.pc          = r_pc;
   assign bus.if_id_npc   = r_npc;
   assign bus.if_id_instr = r_instr;
   assign bus.if_id_valid = r_valid;

   always_comb begin
      w_state_n      = r_state;
      w_pc_n         = r_pc;
      w_hold_instr_n = r_hold_instr;
      w_drain_addr_n = r_drain_addr;
      w_npc_n        = r_npc;
      w_instr_n      = r_instr;
      w_valid_n      = r_valid;

      case (r_state)
         S_FETCH: begin
            if (bus.pcsrc) begin
               w_pc_n    = bus.branch_target;
               w_npc_n   = 32'h0;
               w_instr_n = 32'h0;
               w_valid_n = 1'b0;
               if (!bus.imem_ready) begin
                  w_drain_addr_n = w_pc_word;
                  w_state_n      = S_DRAIN;
               end
            end else if (bus.imem_ready) begin
               w_pc_n = w_pc_plus4;
               if (bus.stall) begin
                  w_hold_instr_n = bus.imem_rdata;
                  w_state_n      = S_HOLD;
               end else begin
                  w_npc_n   = w_pc_plus4;
                  w_instr_n = bus.imem_rdata;
                  w_valid_n = 1'b1;
               end
            end else if (!bus.stall) begin
               w_npc_n   = 32'h0;
               w_instr_n = 32'h0;
               w_valid_n = 1'b0;
            end
         end

         S_HOLD: begin
            if (bus.pcsrc) begin
               w_pc_n    = bus.branch_target;
               w_npc_n   = 32'h0;
               w_instr_n = 32'h0;
               w_valid_n = 1'b0;
               w_state_n = S_FETCH;
            end else if (!bus.stall) begin
               // PC was already advanced when the word was parked, so it is this word's npc.
               w_npc_n   = r_pc;
               w_instr_n = r_hold_instr;
               w_valid_n = 1'b1;
               w_state_n = S_FETCH;
            end
         end

         S_DRAIN: begin
            if (bus.imem_ready) begin
               w_state_n = S_FETCH;
            end
            if (bus.pcsrc) begin
               w_pc_n    = bus.branch_target;
               w_npc_n   = 32'h0;
               w_instr_n = 32'h0;
               w_valid_n = 1'b0;
            end else if (!bus.stall) begin
               w_npc_n   = 32'h0;
               w_instr_n = 32'h0;
               w_valid_n = 1'b0;
            end
         end

         default: begin
            w_state_n = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_FETCH;
         r_pc         <= RESET_PC;
         r_hold_instr <= 32'h0;
         r_drain_addr <= '0;
         r_npc        <= 32'h0;
         r_instr      <= 32'h0;
         r_valid      <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_pc         <= w_pc_n;
         r_hold_instr <= w_hold_instr_n;
         r_drain_addr <= w_drain_addr_n;
         r_npc        <= w_npc_n;
         r_instr      <= w_instr_n;
         r_valid      <= w_valid_n;
      end
   end

endmodule
